// File: rtl/uart_pkg.sv
// uart_pkg -- shared constants and types for the UART receiver.
//   DBIT_DEFAULT    : default number of data bits per frame
//   SB_TICK_DEFAULT : default oversampling ticks per stop bit (16 = 1 stop bit)
//   state_t         : receiver FSM state encoding
package uart_pkg;

  localparam int DBIT_DEFAULT    = 8;
  localparam int SB_TICK_DEFAULT = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// sync_2ff -- two-flop synchronizer for a single asynchronous bit.
// Both flops reset to 1 so an idle-high line never looks like a start bit.
// Ports:
//   clk   : system clock (rising edge)
//   reset : synchronous active-high reset
//   i_d   : asynchronous input
//   o_q   : synchronized output (2 clk latency)
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Two-stage capture of the asynchronous input
  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// uart_rx -- 16x-oversampling UART receiver (start, DBIT data LSB first,
// optional even parity, stop).
// Optional feature macro: UART_RX_PARITY_EN (adds PARITY state + even-parity check).
// Ports:
//   clk          : system clock (rising edge)
//   reset        : synchronous active-high reset
//   rx           : asynchronous serial line, idle high
//   s_tick       : 16x oversampling enable, one clk wide
//   dout         : last received data word
//   rx_done_tick : one-clk pulse on frame completion
//   frame_err    : one-clk pulse with rx_done_tick when stop bit sampled 0
//   parity_err   : one-clk pulse with rx_done_tick on parity mismatch (0 when feature off)
module uart_rx
  import uart_pkg::*;
#(
  parameter int DBIT    = DBIT_DEFAULT,
  parameter int SB_TICK = SB_TICK_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  input  logic            s_tick,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            frame_err,
  output logic            parity_err
);

  // Tick counter must reach at least 15 (bit period) and SB_TICK-1 (stop period).
  localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam int NW = $clog2(DBIT);

  localparam logic [SW-1:0] S_MID  = SW'(7);
  localparam logic [SW-1:0] S_LAST = SW'(15);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

  logic            w_rx;
  state_t          r_state, w_state_nx;
  logic [SW-1:0]   r_s, w_s_nx;
  logic [NW-1:0]   r_n, w_n_nx;
  logic [DBIT-1:0] r_b, w_b_nx;
  logic [DBIT-1:0] r_dout, w_dout_nx;
  logic            r_done, w_done_nx;
  logic            r_ferr, w_ferr_nx;
`ifdef UART_RX_PARITY_EN
  logic            r_pmis, w_pmis_nx;
  logic            r_perr, w_perr_nx;

  // Even parity: data bits plus parity bit must XOR to 0.
  function automatic logic parity_mismatch(input logic [DBIT-1:0] data, input logic pbit);
    return ^{pbit, data};
  endfunction
`endif

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (rx),
    .o_q   (w_rx)
  );

  // Next-state and next-output computation
  always_comb begin
    w_state_nx = r_state;
    w_s_nx     = r_s;
    w_n_nx     = r_n;
    w_b_nx     = r_b;
    w_dout_nx  = r_dout;
    w_done_nx  = 1'b0;
    w_ferr_nx  = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_pmis_nx  = r_pmis;
    w_perr_nx  = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        // Start-bit detection does not wait for s_tick.
        if (!w_rx) begin
          w_s_nx     = '0;
          w_state_nx = START;
        end else begin
          w_state_nx = IDLE;
        end
      end
      START: begin
        if (s_tick) begin
          if (r_s == S_MID) begin
            // Mid-start-bit re-check rejects glitches.
            if (w_rx) begin
              w_s_nx     = '0;
              w_state_nx = IDLE;
            end else begin
              w_s_nx     = '0;
              w_n_nx     = '0;
              w_state_nx = DATA;
            end
          end else begin
            w_s_nx = r_s + SW'(1);
          end
        end else begin
          w_s_nx = r_s;
        end
      end
      DATA: begin
        if (s_tick) begin
          if (r_s == S_LAST) begin
            w_s_nx = '0;
            w_b_nx = {w_rx, r_b[DBIT-1:1]};
            if (r_n == N_LAST) begin
`ifdef UART_RX_PARITY_EN
              w_state_nx = PARITY;
`else
              w_state_nx = STOP;
`endif
            end else begin
              w_n_nx = r_n + NW'(1);
            end
          end else begin
            w_s_nx = r_s + SW'(1);
          end
        end else begin
          w_s_nx = r_s;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (s_tick) begin
          if (r_s == S_LAST) begin
            w_s_nx     = '0;
            w_pmis_nx  = parity_mismatch(r_b, w_rx);
            w_state_nx = STOP;
          end else begin
            w_s_nx = r_s + SW'(1);
          end
        end else begin
          w_s_nx = r_s;
        end
      end
`endif
      STOP: begin
        if (s_tick) begin
          if (r_s == S_STOP) begin
            w_s_nx     = '0;
            w_dout_nx  = r_b;
            w_done_nx  = 1'b1;
            w_ferr_nx  = ~w_rx;
`ifdef UART_RX_PARITY_EN
            w_perr_nx  = r_pmis;
`endif
            w_state_nx = IDLE;
          end else begin
            w_s_nx = r_s + SW'(1);
          end
        end else begin
          w_s_nx = r_s;
        end
      end
      default: begin
        w_s_nx     = '0;
        w_state_nx = IDLE;
      end
    endcase
  end

  // State, datapath and registered output pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_s     <= '0;
      r_n     <= '0;
      r_b     <= '0;
      r_dout  <= '0;
      r_done  <= 1'b0;
      r_ferr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_pmis  <= 1'b0;
      r_perr  <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nx;
      r_s     <= w_s_nx;
      r_n     <= w_n_nx;
      r_b     <= w_b_nx;
      r_dout  <= w_dout_nx;
      r_done  <= w_done_nx;
      r_ferr  <= w_ferr_nx;
`ifdef UART_RX_PARITY_EN
      r_pmis  <= w_pmis_nx;
      r_perr  <= w_perr_nx;
`endif
    end
  end

  assign dout         = r_dout;
  assign rx_done_tick = r_done;
  assign frame_err    = r_ferr;
`ifdef UART_RX_PARITY_EN
  assign parity_err   = r_perr;
`else
  assign parity_err   = 1'b0;
`endif

endmodule
